// File: rtl/sseg_scan_n.sv
// sseg_scan_n: N-digit multiplexed seven-segment scanner with hex decode,
// per-digit blanking and decimal points, PWM brightness and frame-synchronous
// (tear-free) display update through a load strobe.
// Optional blink support is compiled in with the macro SSEG_SCAN_BLINK_EN.
module sseg_scan_n #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 65536,
  parameter int DIM_BITS    = 3,
  parameter int ACTIVE_LOW  = 1
`ifdef SSEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIM_BITS-1:0]   brightness,
`ifdef SSEG_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_in,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW:0]   UNIT     = (CW+1)'(REFRESH_DIV >> DIM_BITS);
  localparam logic          OFF      = (ACTIVE_LOW != 0);

  // Hex digit to segment pattern {g,f,e,d,c,b,a}, active-low form.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  boundary;

  logic [4*DIGITS-1:0]   pend_dig_q, disp_dig_q;
  logic [DIGITS-1:0]     pend_dp_q, disp_dp_q;
  logic [DIGITS-1:0]     pend_blank_q, disp_blank_q;
  logic [DIGITS-1:0]     pend_blink_q, disp_blink_q;
  logic [DIM_BITS-1:0]   pend_bright_q, disp_bright_q;
  logic                  pend_valid_q;

  logic [DIGITS-1:0]     blink_src;
  logic                  hide_w;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_done_q;

  assign boundary = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

  // Slot counter and digit index advance.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Scan position registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Load handshake: capture into pending, commit to display only at a frame
  // boundary; a load in the boundary cycle goes straight to the display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_blink_q  <= '0;
      pend_bright_q <= '0;
      pend_valid_q  <= 1'b0;
      disp_dig_q    <= '0;
      disp_dp_q     <= '0;
      disp_blank_q  <= '1;
      disp_blink_q  <= '0;
      disp_bright_q <= '0;
    end else if (boundary && load) begin
      disp_dig_q    <= digits_in;
      disp_dp_q     <= dp_in;
      disp_blank_q  <= blank_in;
      disp_blink_q  <= blink_src;
      disp_bright_q <= brightness;
      pend_valid_q  <= 1'b0;
    end else if (boundary && pend_valid_q) begin
      disp_dig_q    <= pend_dig_q;
      disp_dp_q     <= pend_dp_q;
      disp_blank_q  <= pend_blank_q;
      disp_blink_q  <= pend_blink_q;
      disp_bright_q <= pend_bright_q;
      pend_valid_q  <= 1'b0;
    end else if (load) begin
      pend_dig_q    <= digits_in;
      pend_dp_q     <= dp_in;
      pend_blank_q  <= blank_in;
      pend_blink_q  <= blink_src;
      pend_bright_q <= brightness;
      pend_valid_q  <= 1'b1;
    end
  end

`ifdef SSEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] frm_q;
  logic          hide_q;

  // Frame counter toggling the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frm_q  <= '0;
      hide_q <= 1'b0;
    end else if (boundary) begin
      if (frm_q == FRM_LAST) begin
        frm_q  <= '0;
        hide_q <= ~hide_q;
      end else begin
        frm_q <= frm_q + FW'(1);
      end
    end
  end

  assign blink_src = blink_in;
  assign hide_w    = hide_q;
`else
  assign blink_src = '0;
  assign hide_w    = 1'b0;
`endif

  // Next output values for the current slot; cnt == 0 is the dark guard cycle.
  always_comb begin
    logic [3:0]         nib;
    logic               blank_eff;
    logic [CW:0]        on_len;
    logic               lit;
    logic [DIGITS-1:0]  sel;
    logic [6:0]         seg_act;
    logic               dp_act;
    nib       = disp_dig_q[4*int'(idx_q) +: 4];
    blank_eff = disp_blank_q[idx_q] | (disp_blink_q[idx_q] & hide_w);
    on_len    = ({{(CW+1-DIM_BITS){1'b0}}, disp_bright_q} + (CW+1)'(1)) * UNIT;
    lit       = (cnt_q != '0) && ({1'b0, cnt_q} < on_len);
    sel       = lit ? (DIGITS'(1) << idx_q) : '0;
    seg_act   = blank_eff ? 7'b0000000 : ~hex7(nib);
    dp_act    = ~blank_eff & disp_dp_q[idx_q];
    an_d      = OFF ? ~sel : sel;
    seg_d     = OFF ? ~seg_act : seg_act;
    dp_d      = OFF ? ~dp_act : dp_act;
  end

  // Registered pin drivers and frame-done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q         <= {DIGITS{OFF}};
      seg_q        <= {7{OFF}};
      dp_q         <= OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= boundary;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_n.sv
// Directed testbench for sseg_scan_n (DIGITS=4, REFRESH_DIV=16, DIM_BITS=2,
// ACTIVE_LOW=1). Blink scenario compiled in with SSEG_SCAN_BLINK_EN.
module tb_sseg_scan_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
`ifdef SSEG_SCAN_BLINK_EN
  logic [3:0]  blink_in;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] an_s  [64];
  logic [6:0] seg_s [64];
  logic       dp_s  [64];
  logic       fd_s  [64];

  sseg_scan_n #(
    .DIGITS(4), .REFRESH_DIV(16), .DIM_BITS(2), .ACTIVE_LOW(1)
`ifdef SSEG_SCAN_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clock(clk), .reset(rst), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
    .brightness(brightness),
`ifdef SSEG_SCAN_BLINK_EN
    .blink_in(blink_in),
`endif
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference segment table, active-low {g..a}.
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Sample n of a frame corresponds to slot n/16, cnt n%16.
  function automatic logic [3:0] exp_an(input int n, input int onlen);
    int c;
    int s;
    c = n % 16;
    s = n / 16;
    if (c >= 1 && c < onlen) return ~(4'b0001 << s);
    return 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic [3:0] blk, input int n);
    int s;
    s = n / 16;
    if (blk[s]) return 7'b1111111;
    return dec7(d[4*s +: 4]);
  endfunction

  function automatic logic exp_dp(input logic [3:0] dpv, input logic [3:0] blk, input int n);
    int s;
    s = n / 16;
    return !(dpv[s] && !blk[s]);
  endfunction

  task automatic sample(input int n);
    an_s[n]  = an;
    seg_s[n] = seg;
    dp_s[n]  = dp;
    fd_s[n]  = frame_done;
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dpv,
                            input logic [3:0] blk, input logic [1:0] br);
    digits_in  = d;
    dp_in      = dpv;
    blank_in   = blk;
    brightness = br;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_done !== 1'b1 && cyc < 200);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done timeout: got %b after %0d cycles, required 1", frame_done, cyc);
    end
  endtask

  task automatic capture();
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      @(negedge clk);
      sample(n);
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    load = 1'b0;
    set_inputs(16'h0000, 4'b0000, 4'b0000, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset an: got %b, required 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset seg: got %b, required 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset dp: got %b, required 1", dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b, required 0", frame_done); end
    @(negedge clk);
    rst = 1'b0;
    // Light the display, then leave a load pending and reset mid-frame.
    set_inputs(16'h3A07, 4'b0100, 4'b0000, 2'd3);
    pulse_load();
    wait_fd(cyc);
    repeat (20) @(negedge clk);
    set_inputs(16'hFFFF, 4'b0000, 4'b0000, 2'd3);
    pulse_load();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async reset an: got %b, required 1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL async reset seg: got %b, required 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async reset dp: got %b, required 1", dp); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL async reset frame_done: got %b, required 0", frame_done); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_fd(cyc);
    checks++; if (cyc != 64) begin errors++; $display("FAIL first frame length: got %0d, required 64", cyc); end
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (seg_s[n] !== 7'b1111111) begin errors++; $display("FAIL dark seg[%0d]: got %b, required 1111111", n, seg_s[n]); end
      checks++; if (dp_s[n] !== 1'b1) begin errors++; $display("FAIL dark dp[%0d]: got %b, required 1", n, dp_s[n]); end
      checks++; if (fd_s[n] !== (n == 63)) begin errors++; $display("FAIL frame_done[%0d]: got %b, required %b", n, fd_s[n], (n == 63)); end
    end
  endtask

  task automatic test_digits();
    int cyc;
    set_inputs(16'h3A07, 4'b0100, 4'b0000, 2'd3);
    pulse_load();
    wait_fd(cyc);
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 16)) begin errors++; $display("FAIL digits an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 16)); end
      checks++; if (seg_s[n] !== exp_seg(16'h3A07, 4'b0000, n)) begin errors++; $display("FAIL digits seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'h3A07, 4'b0000, n)); end
      checks++; if (dp_s[n] !== exp_dp(4'b0100, 4'b0000, n)) begin errors++; $display("FAIL digits dp[%0d]: got %b, required %b", n, dp_s[n], exp_dp(4'b0100, 4'b0000, n)); end
    end
  endtask

  task automatic test_dim();
    int cyc;
    set_inputs(16'h3A07, 4'b0100, 4'b0000, 2'd0);
    pulse_load();
    wait_fd(cyc);
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 4)) begin errors++; $display("FAIL dim an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 4)); end
      checks++; if (seg_s[n] !== exp_seg(16'h3A07, 4'b0000, n)) begin errors++; $display("FAIL dim seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'h3A07, 4'b0000, n)); end
    end
  endtask

  task automatic test_back_to_back();
    // Two loads inside one frame; the frame itself must stay untouched.
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      @(negedge clk);
      sample(n);
      if (n == 20) begin set_inputs(16'h1111, 4'b0100, 4'b0000, 2'd0); load = 1'b1; end
      if (n == 21) load = 1'b0;
      if (n == 36) begin set_inputs(16'h2222, 4'b0100, 4'b0000, 2'd3); load = 1'b1; end
      if (n == 37) load = 1'b0;
    end
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 4)) begin errors++; $display("FAIL b2b cur an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 4)); end
      checks++; if (seg_s[n] !== exp_seg(16'h3A07, 4'b0000, n)) begin errors++; $display("FAIL b2b cur seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'h3A07, 4'b0000, n)); end
    end
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 16)) begin errors++; $display("FAIL b2b next an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 16)); end
      checks++; if (seg_s[n] !== exp_seg(16'h2222, 4'b0000, n)) begin errors++; $display("FAIL b2b next seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'h2222, 4'b0000, n)); end
    end
  endtask

  task automatic test_boundary_load();
    int cyc;
    // Load presented exactly in the frame-boundary cycle (slot3, cnt15).
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      @(negedge clk);
      sample(n);
      if (n == 62) begin set_inputs(16'hFFFF, 4'b0000, 4'b0000, 2'd3); load = 1'b1; end
      if (n == 63) load = 1'b0;
    end
    for (int n = 0; n < 64; n++) begin
      checks++; if (seg_s[n] !== exp_seg(16'h2222, 4'b0000, n)) begin errors++; $display("FAIL bnd cur seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'h2222, 4'b0000, n)); end
    end
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 16)) begin errors++; $display("FAIL bnd an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 16)); end
      checks++; if (seg_s[n] !== 7'b0001110) begin errors++; $display("FAIL bnd seg[%0d]: got %b, required 0001110", n, seg_s[n]); end
      checks++; if (dp_s[n] !== 1'b1) begin errors++; $display("FAIL bnd dp[%0d]: got %b, required 1", n, dp_s[n]); end
    end
    // Blank digit 1 with dp requested on it; anode must still pulse.
    set_inputs(16'hFFFF, 4'b0010, 4'b0010, 2'd1);
    pulse_load();
    wait_fd(cyc);
    capture();
    for (int n = 0; n < 64; n++) begin
      checks++; if (an_s[n] !== exp_an(n, 8)) begin errors++; $display("FAIL blank an[%0d]: got %b, required %b", n, an_s[n], exp_an(n, 8)); end
      checks++; if (seg_s[n] !== exp_seg(16'hFFFF, 4'b0010, n)) begin errors++; $display("FAIL blank seg[%0d]: got %b, required %b", n, seg_s[n], exp_seg(16'hFFFF, 4'b0010, n)); end
      checks++; if (dp_s[n] !== exp_dp(4'b0010, 4'b0010, n)) begin errors++; $display("FAIL blank dp[%0d]: got %b, required %b", n, dp_s[n], exp_dp(4'b0010, 4'b0010, n)); end
    end
  endtask

`ifdef SSEG_SCAN_BLINK_EN
  task automatic test_blink();
    int   cyc;
    logic vis [6];
    logic [6:0] s1 [6];
    blink_in = 4'b0001;
    set_inputs(16'h8888, 4'b0000, 4'b0000, 2'd3);
    pulse_load();
    blink_in = 4'b0000;
    wait_fd(cyc);
    for (int f = 0; f < 6; f++) begin
      capture();
      vis[f] = (seg_s[5] !== 7'b1111111);
      s1[f]  = seg_s[21];
    end
    for (int f = 0; f < 4; f++) begin
      checks++; if (vis[f] === vis[f+2]) begin errors++; $display("FAIL blink phase frame %0d: got %b, required %b", f + 2, vis[f+2], !vis[f]); end
    end
    for (int f = 0; f < 6; f++) begin
      checks++; if (s1[f] !== 7'b0000000) begin errors++; $display("FAIL blink steady digit1 frame %0d: got %b, required 0000000", f, s1[f]); end
    end
  endtask
`endif

  initial begin
`ifdef SSEG_SCAN_BLINK_EN
    blink_in = 4'b0000;
`endif
    test_reset();
    test_digits();
    test_dim();
    test_back_to_back();
    test_boundary_load();
`ifdef SSEG_SCAN_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
